// File: rtl/iter_2d.sv
// Raster-scan point generator: walks (x,y) over a 2-D grid in row-major order,
// presenting one point per cycle under a valid/ready handshake.
module iter_2d #(
    parameter int X_MAX_VALUE = 3,
    parameter int Y_MAX_VALUE = 2,
    parameter int X_WIDTH     = $clog2(X_MAX_VALUE + 1),
    parameter int Y_WIDTH     = $clog2(Y_MAX_VALUE + 1),
    parameter bit CONTINUOUS  = 1'b0,
    localparam int XW = (X_WIDTH < 1) ? 1 : X_WIDTH,
    localparam int YW = (Y_WIDTH < 1) ? 1 : Y_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          ready,
    output logic          valid,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          row_last,
    output logic          last,
    output logic          busy,
    output logic          done
);

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    localparam logic [XW-1:0] X_LAST = XW'(X_MAX_VALUE);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_MAX_VALUE);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);

    logic state;
    logic handshake;

    // Handshake: a point transfers on a rising edge where valid && ready are
    // both high; valid, x and y never change while valid is high and ready low.
    assign valid     = (state == RUN);
    assign busy      = (state == RUN);
    assign handshake = valid && ready;
    assign row_last  = valid && (x == X_LAST);
    assign last      = row_last && (y == Y_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    x <= '0;
                    y <= '0;
                    if (start && !abort) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // abort outranks a coincident handshake, so no done pulse
                    if (abort) begin
                        state <= IDLE;
                        x     <= '0;
                        y     <= '0;
                    end else if (handshake) begin
                        if (last) begin
                            done <= 1'b1;
                            x    <= '0;
                            y    <= '0;
                            if (!CONTINUOUS) begin
                                state <= IDLE;
                            end
                        end else if (row_last) begin
                            x <= '0;
                            y <= y + Y_ONE;
                        end else begin
                            x <= x + X_ONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    x     <= '0;
                    y     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_2d.sv
// Directed bench for iter_2d: single-pass 4x3 grid, continuous 4x3 grid and a
// degenerate 1x1 grid, each on its own instance sharing clock and reset.
module tb_iter_2d;

  logic clk;
  logic reset;

  logic start_a, abort_a, ready_a;
  logic valid_a, row_last_a, last_a, busy_a, done_a;
  logic [1:0] x_a, y_a;

  logic start_b, abort_b, ready_b;
  logic valid_b, row_last_b, last_b, busy_b, done_b;
  logic [1:0] x_b, y_b;

  logic start_c, abort_c, ready_c;
  logic valid_c, row_last_c, last_c, busy_c, done_c;
  logic [0:0] x_c, y_c;

  int n_checks;
  int n_fail;

  iter_2d #(.X_MAX_VALUE(3), .Y_MAX_VALUE(2), .CONTINUOUS(1'b0)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .ready(ready_a),
    .valid(valid_a), .x(x_a), .y(y_a), .row_last(row_last_a), .last(last_a),
    .busy(busy_a), .done(done_a)
  );

  iter_2d #(.X_MAX_VALUE(3), .Y_MAX_VALUE(2), .CONTINUOUS(1'b1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .ready(ready_b),
    .valid(valid_b), .x(x_b), .y(y_b), .row_last(row_last_b), .last(last_b),
    .busy(busy_b), .done(done_b)
  );

  iter_2d #(.X_MAX_VALUE(0), .Y_MAX_VALUE(0), .CONTINUOUS(1'b0)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .abort(abort_c), .ready(ready_c),
    .valid(valid_c), .x(x_c), .y(y_c), .row_last(row_last_c), .last(last_c),
    .busy(busy_c), .done(done_c)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_valid"}, {31'd0, valid_a}, 32'd0);
    check({tag, "_x"}, {30'd0, x_a}, 32'd0);
    check({tag, "_y"}, {30'd0, y_a}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
  endtask

  task automatic check_point_a(input string tag, input int k);
    check({tag, "_valid"}, {31'd0, valid_a}, 32'd1);
    check({tag, "_x"}, {30'd0, x_a}, k % 4);
    check({tag, "_y"}, {30'd0, y_a}, k / 4);
    check({tag, "_row_last"}, {31'd0, row_last_a}, {31'd0, (k % 4) == 3});
    check({tag, "_last"}, {31'd0, last_a}, {31'd0, k == 11});
  endtask

  task automatic start_pulse_a;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  initial begin
    int k;
    int cyc;
    n_checks = 0;
    n_fail   = 0;
    {start_a, abort_a, ready_a} = 3'b000;
    {start_b, abort_b, ready_b} = 3'b000;
    {start_c, abort_c, ready_c} = 3'b000;
    reset = 1'b0;
    repeat (3) tick();
    check_idle_a("rst");
    check("rst_done", {31'd0, done_a}, 32'd0);
    reset = 1'b1;
    repeat (2) tick();
    check_idle_a("post_rst_wait");

    // full pass with ready held high
    ready_a = 1'b1;
    start_pulse_a();
    for (int i = 0; i < 12; i++) begin
      check_point_a("pass1", i);
      check("pass1_done", {31'd0, done_a}, 32'd0);
      tick();
    end
    check("pass1_done_pulse", {31'd0, done_a}, 32'd1);
    check_idle_a("pass1_end");
    tick();
    check("pass1_done_clear", {31'd0, done_a}, 32'd0);

    // pseudo-random ready, plus a start while running that must be ignored
    k = 0;
    cyc = 0;
    ready_a = 1'b0;
    start_pulse_a();
    while (k < 12 && cyc < 300) begin
      ready_a = 1'($urandom_range(0, 1));
      start_a = (cyc == 5);
      check_point_a("rand", k);
      tick();
      if (ready_a) k++;
      cyc++;
    end
    start_a = 1'b0;
    check("rand_timeout", {31'd0, k == 12}, 32'd1);
    check("rand_done_pulse", {31'd0, done_a}, 32'd1);
    check_idle_a("rand_end");
    ready_a = 1'b0;
    tick();
    check("rand_done_clear", {31'd0, done_a}, 32'd0);

    // abort at (1,1)
    ready_a = 1'b1;
    start_pulse_a();
    repeat (5) tick();
    check_point_a("pre_abort", 5);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check_idle_a("abort");
    check("abort_done", {31'd0, done_a}, 32'd0);
    tick();
    check("abort_done2", {31'd0, done_a}, 32'd0);
    check_idle_a("abort_stay");

    // start with abort in IDLE stays IDLE
    start_a = 1'b1;
    abort_a = 1'b1;
    tick();
    start_a = 1'b0;
    abort_a = 1'b0;
    check_idle_a("start_abort");

    // rescan; abort on the final handshake suppresses done
    start_pulse_a();
    check_point_a("rescan", 0);
    repeat (11) tick();
    check_point_a("pre_final_abort", 11);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check("final_abort_done", {31'd0, done_a}, 32'd0);
    check_idle_a("final_abort");

    // asynchronous reset at (2,1), no clock edge in between
    start_pulse_a();
    repeat (6) tick();
    check_point_a("pre_reset", 6);
    ready_a = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_idle_a("async_rst");
    check("async_rst_done", {31'd0, done_a}, 32'd0);
    #1 reset = 1'b1;
    repeat (3) tick();
    check_idle_a("rst_wait_start");
    start_pulse_a();
    check_point_a("rst_resume", 0);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;

    // continuous mode: 30 cycles, wraps straight from (3,2) to (0,0)
    ready_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 30; i++) begin
      check("cont_valid", {31'd0, valid_b}, 32'd1);
      check("cont_x", {30'd0, x_b}, (i % 12) % 4);
      check("cont_y", {30'd0, y_b}, (i % 12) / 4);
      check("cont_last", {31'd0, last_b}, {31'd0, (i % 12) == 11});
      check("cont_done", {31'd0, done_b}, {31'd0, (i % 12) == 0 && i > 0});
      tick();
    end
    abort_b = 1'b1;
    tick();
    abort_b = 1'b0;
    check("cont_abort_valid", {31'd0, valid_b}, 32'd0);

    // 1x1 grid: every handshake is final
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    tick();
    check("one_valid_hold", {31'd0, valid_c}, 32'd1);
    check("one_x", {31'd0, x_c}, 32'd0);
    check("one_y", {31'd0, y_c}, 32'd0);
    check("one_row_last", {31'd0, row_last_c}, 32'd1);
    check("one_last", {31'd0, last_c}, 32'd1);
    ready_c = 1'b1;
    tick();
    ready_c = 1'b0;
    check("one_done", {31'd0, done_c}, 32'd1);
    check("one_valid_end", {31'd0, valid_c}, 32'd0);
    check("one_busy_end", {31'd0, busy_c}, 32'd0);
    tick();
    check("one_done_clear", {31'd0, done_c}, 32'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
